// File: rtl/d2of5_decoder.sv
// 2-of-5 to BCD decoder with registered outputs and a saturating invalid-word counter.
// Decode is combinational; results and counter update on the accepting clock edge.
module d2of5_decoder #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [4:0]           d2_5,
  input  logic                 clr_cnt,
  output logic                 out_valid,
  output logic [3:0]           dout,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]           DOUT_BAD = 4'hF;

  logic [2:0] ones_c;
  logic [3:0] sum_c;
  logic       legal_c;
  logic [3:0] digit_c;

  // Weighted sum 7-4-2-1-0; the 7+4 pattern is the encoding of digit zero.
  always_comb begin
    ones_c  = 3'(d2_5[0]) + 3'(d2_5[1]) + 3'(d2_5[2]) + 3'(d2_5[3]) + 3'(d2_5[4]);
    sum_c   = (d2_5[4] ? 4'd7 : 4'd0) + (d2_5[3] ? 4'd4 : 4'd0)
            + (d2_5[2] ? 4'd2 : 4'd0) + (d2_5[1] ? 4'd1 : 4'd0);
    legal_c = (ones_c == 3'd2);
    digit_c = DOUT_BAD;
    if (legal_c) begin
      digit_c = (sum_c == 4'd11) ? 4'd0 : sum_c;
    end
  end

  // Output word register; dout/err hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= 4'h0;
      err       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        dout <= digit_c;
        err  <= ~legal_c;
      end
    end
  end

  // Clear wins over a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (in_valid && !legal_c && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_d2of5_decoder.sv
// Randomized self-checking bench for d2of5_decoder against a weight-sum reference model.
// Two instances share stimulus: default counter width and a 2-bit counter for saturation.
module tb_d2of5_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] d2_5;
  logic       clr_cnt;

  logic       ov8, err8, ov2, err2;
  logic [3:0] dout8, dout2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic       m_valid;
  logic [3:0] m_dout;
  logic       m_err;
  int         m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  d2of5_decoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d2_5(d2_5), .clr_cnt(clr_cnt),
    .out_valid(ov8), .dout(dout8), .err(err8), .err_cnt(cnt8)
  );

  d2of5_decoder #(.ERR_CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d2_5(d2_5), .clr_cnt(clr_cnt),
    .out_valid(ov2), .dout(dout2), .err(err2), .err_cnt(cnt2)
  );

  function automatic logic [3:0] ref_digit(input logic [4:0] w);
    int weight[5] = '{0, 1, 2, 4, 7};
    int ones = 0;
    int sum = 0;
    for (int i = 0; i < 5; i++) begin
      if (w[i]) begin
        ones++;
        sum += weight[i];
      end
    end
    if (ones != 2) return 4'hF;
    if (sum == 11) return 4'h0;
    return 4'(sum);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_dout  = 4'h0;
    m_err   = 1'b0;
    m_cnt8  = 0;
    m_cnt2  = 0;
  endtask

  // Apply one cycle of stimulus, advance the model on the edge, return at the next negedge.
  task automatic step(input logic v, input logic [4:0] d, input logic c);
    logic [3:0] dig;
    in_valid = v;
    d2_5     = d;
    clr_cnt  = c;
    @(posedge clk);
    if (rst_n) begin
      dig = ref_digit(d);
      if (c) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (v && dig == 4'hF) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_valid = v;
      if (v) begin
        m_dout = dig;
        m_err  = (dig == 4'hF);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    d2_5 = 5'b11111;
    clr_cnt = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ov8, dout8, err8, cnt8} !== 14'h0) begin
      errors++;
      $display("FAIL reset_w8: got ov=%b dout=%h err=%b cnt=%0d expected all zero", ov8, dout8, err8, cnt8);
    end
    checks++;
    if ({ov2, dout2, err2, cnt2} !== 8'h0) begin
      errors++;
      $display("FAIL reset_w2: got ov=%b dout=%h err=%b cnt=%0d expected all zero", ov2, dout2, err2, cnt2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 5'(i), 1'b0);
      checks++;
      if (ov8 !== 1'b1 || dout8 !== m_dout || err8 !== m_err) begin
        errors++;
        $display("FAIL sweep_%0d: got ov=%b dout=%h err=%b expected ov=1 dout=%h err=%b",
                 i, ov8, dout8, err8, m_dout, m_err);
      end
      if (i == 10) begin
        checks++;
        if (dout8 !== 4'd5 || err8 !== 1'b0) begin
          errors++;
          $display("FAIL sweep_01010: got dout=%h err=%b expected dout=5 err=0", dout8, err8);
        end
      end
      if (i == 7) begin
        checks++;
        if (dout8 !== 4'hF || err8 !== 1'b1) begin
          errors++;
          $display("FAIL sweep_00111: got dout=%h err=%b expected dout=f err=1", dout8, err8);
        end
      end
    end
    checks++;
    if (cnt8 !== 8'd22) begin
      errors++;
      $display("FAIL sweep_cnt: got %0d expected 22", cnt8);
    end
  endtask

  task automatic test_latency_hold();
    step(1'b1, 5'b11000, 1'b0);
    checks++;
    if (ov8 !== 1'b1 || dout8 !== 4'd0 || err8 !== 1'b0) begin
      errors++;
      $display("FAIL latency: got ov=%b dout=%h err=%b expected ov=1 dout=0 err=0", ov8, dout8, err8);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'($urandom_range(31)), 1'b0);
      checks++;
      if (ov8 !== 1'b0 || dout8 !== 4'd0 || err8 !== 1'b0 || cnt8 !== 8'(m_cnt8)) begin
        errors++;
        $display("FAIL hold_%0d: got ov=%b dout=%h err=%b cnt=%0d expected ov=0 dout=0 err=0 cnt=%0d",
                 i, ov8, dout8, err8, cnt8, m_cnt8);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(3) != 0), 5'($urandom_range(31)), 1'($urandom_range(15) == 0));
      checks++;
      if (ov8 !== m_valid || dout8 !== m_dout || err8 !== m_err || cnt8 !== 8'(m_cnt8)) begin
        errors++;
        $display("FAIL random_w8_%0d: got ov=%b dout=%h err=%b cnt=%0d expected ov=%b dout=%h err=%b cnt=%0d",
                 i, ov8, dout8, err8, cnt8, m_valid, m_dout, m_err, m_cnt8);
      end
      checks++;
      if (ov2 !== m_valid || dout2 !== m_dout || err2 !== m_err || cnt2 !== 2'(m_cnt2)) begin
        errors++;
        $display("FAIL random_w2_%0d: got ov=%b dout=%h err=%b cnt=%0d expected ov=%b dout=%h err=%b cnt=%0d",
                 i, ov2, dout2, err2, cnt2, m_valid, m_dout, m_err, m_cnt2);
      end
    end
  endtask

  task automatic test_saturation();
    int seq[5] = '{1, 2, 3, 3, 3};
    step(1'b0, 5'b00000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5'b11111, 1'b0);
      checks++;
      if (cnt2 !== 2'(seq[i]) || cnt8 !== 8'(i + 1)) begin
        errors++;
        $display("FAIL saturate_%0d: got cnt2=%0d cnt8=%0d expected cnt2=%0d cnt8=%0d",
                 i, cnt2, cnt8, seq[i], i + 1);
      end
    end
  endtask

  task automatic test_clear_collision();
    step(1'b1, 5'b11111, 1'b1);
    checks++;
    if (cnt2 !== 2'd0 || cnt8 !== 8'd0 || ov8 !== 1'b1 || err8 !== 1'b1 || dout8 !== 4'hF) begin
      errors++;
      $display("FAIL clr_collision: got cnt2=%0d cnt8=%0d ov=%b err=%b dout=%h expected 0 0 1 1 f",
               cnt2, cnt8, ov8, err8, dout8);
    end
    step(1'b1, 5'b11111, 1'b0);
    checks++;
    if (cnt2 !== 2'd1 || cnt8 !== 8'd1) begin
      errors++;
      $display("FAIL clr_then_inc: got cnt2=%0d cnt8=%0d expected 1 1", cnt2, cnt8);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 5'b00000, 1'b1);
    step(1'b1, 5'b11111, 1'b0);
    step(1'b1, 5'b11111, 1'b0);
    step(1'b1, 5'b10001, 1'b0);
    checks++;
    if (ov8 !== 1'b1 || dout8 !== 4'd7 || cnt8 !== 8'd2) begin
      errors++;
      $display("FAIL pre_reset: got ov=%b dout=%h cnt=%0d expected ov=1 dout=7 cnt=2", ov8, dout8, cnt8);
    end
    in_valid = 1'b1;
    d2_5 = 5'b01010;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ov8, dout8, err8, cnt8} !== 14'h0 || {ov2, dout2, err2, cnt2} !== 8'h0) begin
      errors++;
      $display("FAIL async_reset: got ov=%b dout=%h err=%b cnt=%0d expected all zero before edge",
               ov8, dout8, err8, cnt8);
    end
    @(negedge clk);
    step(1'b1, 5'b11111, 1'b0);
    checks++;
    if ({ov8, dout8, err8, cnt8} !== 14'h0) begin
      errors++;
      $display("FAIL reset_ignores_input: got ov=%b dout=%h err=%b cnt=%0d expected all zero",
               ov8, dout8, err8, cnt8);
    end
    rst_n = 1'b1;
    step(1'b1, 5'b00011, 1'b0);
    checks++;
    if (ov8 !== 1'b1 || dout8 !== 4'd1 || err8 !== 1'b0 || cnt8 !== 8'd0) begin
      errors++;
      $display("FAIL first_after_reset: got ov=%b dout=%h err=%b cnt=%0d expected ov=1 dout=1 err=0 cnt=0",
               ov8, dout8, err8, cnt8);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 5'($urandom_range(31)), 1'b0);
      checks++;
      if (ov8 !== 1'b1 || dout8 !== m_dout || err8 !== m_err || cnt8 !== 8'(m_cnt8)) begin
        errors++;
        $display("FAIL back_to_back_%0d: got ov=%b dout=%h err=%b cnt=%0d expected ov=1 dout=%h err=%b cnt=%0d",
                 i, ov8, dout8, err8, cnt8, m_dout, m_err, m_cnt8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_latency_hold();
    test_random();
    test_saturation();
    test_clear_collision();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
